cordic_ctrl: RTL and testbench

- Sequencing controller for the iterative CORDIC datapath.
- Accepts a host start request and drives the datapath control word `c[8:1]` and iteration index `cnt` for one rotation: load, N−1 in-place micro-rotations, then two scaled write-backs of the result.
- Signals completion to the host.
- Sits between the host/bus-side wrapper and the CORDIC datapath core, one controller per core.

---
 rtl/cordic_ctrl.sv | 71 +++++++
 tb/tb_cordic_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/cordic_ctrl.sv
// Sequencing controller for the iterative CORDIC datapath: load, N-1 micro-rotations,
// X/Y scaled write-back, then a one-cycle done pulse. All outputs are Moore.
module cordic_ctrl #(
  parameter  int N  = 7,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic          o_ready,
  output logic          o_done,
  output logic [8:1]    o_c,
  output logic [CW-1:0] o_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ITER, S_WR_X, S_WR_Y, S_DONE
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
  localparam logic [CW-1:0] ITER_END = CW'((N > 1) ? N - 2 : 0);

  state_t        r_state, w_nxt;
  logic [CW-1:0] r_cnt;

  // The last ITER cycle advances the counter to N-1, which is exactly the
  // shift amount the write-back states present; it saturates there.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt == S_LOAD)
        r_cnt <= '0;
      else if (r_state == S_ITER && r_cnt != LAST_CNT)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_nxt = S_LOAD;
      S_LOAD: w_nxt = (N > 1) ? S_ITER : S_WR_X;
      S_ITER: if (r_cnt == ITER_END) w_nxt = S_WR_X;
      S_WR_X: w_nxt = S_WR_Y;
      S_WR_Y: w_nxt = S_DONE;
      S_DONE: w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // c[8]=angle en, c[7]=Y en, c[6]=X en, c[5]=mid mux right, c[2]=work en, c[1]=load mux
  always_comb begin
    o_c     = 8'h00;
    o_cnt   = '0;
    o_ready = 1'b0;
    o_done  = 1'b0;
    case (r_state)
      S_IDLE: o_ready = 1'b1;
      S_LOAD: o_c = 8'h83;
      S_ITER: begin o_c = 8'h02; o_cnt = r_cnt; end
      S_WR_X: begin o_c = 8'h20; o_cnt = r_cnt; end
      S_WR_Y: begin o_c = 8'h50; o_cnt = r_cnt; end
      S_DONE: o_done = 1'b1;
      default: o_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cordic_ctrl.sv
// Directed bench for cordic_ctrl: N=7 and N=1 instances side by side on a shared clock/reset.
module tb_cordic_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       st7 = 1'b0, st1 = 1'b0;
  logic       rdy7, dn7, rdy1, dn1;
  logic [8:1] c7, c1;
  logic [2:0] cnt7;
  logic [0:0] cnt1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cordic_ctrl #(.N(7)) u7 (
    .i_clk(clk), .i_rst(rst), .i_start(st7),
    .o_ready(rdy7), .o_done(dn7), .o_c(c7), .o_cnt(cnt7)
  );

  cordic_ctrl #(.N(1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_start(st1),
    .o_ready(rdy1), .o_done(dn1), .o_c(c1), .o_cnt(cnt1)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk7(input string tag, input int c, input int cnt, input int rdy, input int dn);
    chk({tag, " c"},     int'(c7),   c);
    chk({tag, " cnt"},   int'(cnt7), cnt);
    chk({tag, " ready"}, int'(rdy7), rdy);
    chk({tag, " done"},  int'(dn7),  dn);
  endtask

  // One full N=7 operation from the start-sampling edge; inj pulses start in ITER and DONE.
  task automatic op7(input string tag, input bit inj);
    st7 = 1'b1;
    step(); st7 = 1'b0;
    chk7({tag, " LOAD"}, 'h83, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      st7 = (inj && k == 1);
      chk7($sformatf("%s ITER%0d", tag, k), 'h02, k, 0, 0);
    end
    st7 = 1'b0;
    step(); chk7({tag, " WR_X"}, 'h20, 6, 0, 0);
    step(); chk7({tag, " WR_Y"}, 'h50, 6, 0, 0);
    step(); chk7({tag, " DONE"}, 'h00, 0, 0, 1);
    st7 = inj;
    step(); st7 = 1'b0;
    chk7({tag, " IDLE"}, 'h00, 0, 1, 0);
  endtask

  initial begin
    #3;
    chk7("rst async", 'h00, 0, 1, 0);
    chk("rst n1 c", int'(c1), 0);
    chk("rst n1 ready", int'(rdy1), 1);
    step(); step();
    rst = 1'b1;
    step();
    chk7("post-rst idle", 'h00, 0, 1, 0);

    op7("basic", 1'b0);
    op7("inj", 1'b1);
    step(); chk7("inj no retrig", 'h00, 0, 1, 0);

    // Held start: ops back to back with one IDLE cycle between them.
    st7 = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      step();
      if (cyc == 29) st7 = 1'b0;
      chk($sformatf("hold done@%0d", cyc), int'(dn7),
          (cyc == 10 || cyc == 21 || cyc == 32) ? 1 : 0);
      chk($sformatf("hold ready@%0d", cyc), int'(rdy7),
          (cyc == 11 || cyc == 22 || cyc >= 33) ? 1 : 0);
    end

    // Async reset in the middle of ITER.
    st7 = 1'b1;
    step(); st7 = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk7("pre-abort ITER3", 'h02, 3, 0, 0);
    #2 rst = 1'b0;
    #1 chk7("abort async", 'h00, 0, 1, 0);
    step();
    chk7("abort held", 'h00, 0, 1, 0);
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("abort no done %0d", k), int'(dn7), 0);
    end
    op7("after abort", 1'b0);

    // N=1: LOAD straight into write-back.
    st1 = 1'b1;
    step(); st1 = 1'b0;
    chk("n1 LOAD c", int'(c1), 'h83);
    chk("n1 LOAD cnt", int'(cnt1), 0);
    step();
    chk("n1 WR_X c", int'(c1), 'h20);
    chk("n1 WR_X cnt", int'(cnt1), 0);
    step();
    chk("n1 WR_Y c", int'(c1), 'h50);
    chk("n1 WR_Y cnt", int'(cnt1), 0);
    step();
    chk("n1 DONE done", int'(dn1), 1);
    chk("n1 DONE c", int'(c1), 0);
    chk("n1 DONE ready", int'(rdy1), 0);
    step();
    chk("n1 IDLE ready", int'(rdy1), 1);
    chk("n1 IDLE done", int'(dn1), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
